upe_led_serializer: RTL

UPE_LED_SERIALIZER -- requirements
Module: upe_led_serializer

---
 rtl/upe_led_serializer.sv | 108 ++++++++++
 1 files changed

// File: rtl/upe_led_serializer.sv
// upe_led_serializer: shows a WIDTH-bit product word on one LED, LSB first.
// Each bit stays on the LED for DWELL clock cycles. After the last bit the
// LED is held blank for GAP bit-periods. Handshake: a word is transferred on
// a rising edge where in_valid and in_ready are both high. in_ready is high
// only in IDLE and depends on nothing but the FSM state. in_valid and in_data
// are ignored while a frame or gap is in progress.
module upe_led_serializer #(
  parameter int WIDTH = 32,
  parameter int DWELL = 1001,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             led_data,
  output logic             led_frame,
  output logic             led_busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  // One counter serves both the per-bit dwell and the blank period after the frame.
  localparam int GAP_CYC = GAP * DWELL;
  localparam int CNT_MAX = (DWELL > GAP_CYC) ? DWELL : GAP_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [IW-1:0] BIT_LAST   = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             done_q;

  // Main FSM: accept a word, shift it out bit by bit, blank for the gap, then pulse done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sr     <= '0;
      idx    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sr    <= in_data;
            idx   <= '0;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt == DWELL_LAST) begin
            cnt <= '0;
            sr  <= sr >> 1;
            if (idx == BIT_LAST) begin
              idx <= '0;
              if (GAP == 0) begin
                state  <= ST_IDLE;
                done_q <= 1'b1;
              end else begin
                state <= ST_GAP;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt    <= '0;
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state only, never from the inputs.
  assign in_ready  = (state == ST_IDLE);
  assign led_data  = (state == ST_SHIFT) & sr[0];
  assign led_frame = (state == ST_SHIFT) && (idx == '0);
  assign led_busy  = (state != ST_IDLE);
  assign done      = done_q;
  assign fsm_state = state;

endmodule
